// File: rtl/ysyx_23060075_gpr_ctrl.sv
// GPR write-back arbiter and hazard scoreboard.
// Round-robin shares one RF write port between EXU (wb0) and LSU (wb1);
// busy bits stall issue on RAW/WAW until the pending write commits.
// Ports: clk/rst (sync, active-high); issue_* handshake with hazard check;
// wb0_*/wb1_* write-back requests; gpr_w* registered RF write port;
// pending_cnt = popcount(busy); wb_err sticky unexpected write-back.
module ysyx_23060075_gpr_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [ADDR_WIDTH-1:0] issue_rs1,
  input  logic [ADDR_WIDTH-1:0] issue_rs2,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic                  issue_rd_wen,
  input  logic                  wb0_valid,
  output logic                  wb0_ready,
  input  logic [ADDR_WIDTH-1:0] wb0_addr,
  input  logic [DATA_WIDTH-1:0] wb0_data,
  input  logic                  wb1_valid,
  output logic                  wb1_ready,
  input  logic [ADDR_WIDTH-1:0] wb1_addr,
  input  logic [DATA_WIDTH-1:0] wb1_data,
  output logic [DATA_WIDTH-1:0] gpr_w,
  output logic [ADDR_WIDTH-1:0] gpr_w_addr,
  output logic                  gpr_w_en,
  output logic [ADDR_WIDTH:0]   pending_cnt,
  output logic                  wb_err
);

  localparam int NREG = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;

  // 1: wb1 was granted last, so wb0 wins the next contest
  logic last_grant_q;

  logic fire;
  logic set_en;
  logic commit;
  logic cnt_inc;
  logic cnt_dec;
  logic err_set;
  logic grant0;
  logic grant1;

  // Hazard check uses registered busy only
  assign issue_ready = !busy_q[issue_rs1]
                    && !busy_q[issue_rs2]
                    && !(issue_rd_wen && busy_q[issue_rd]);

  assign fire   = issue_valid && issue_ready;
  assign set_en = fire && issue_rd_wen
               && (issue_rd != '0);

  assign commit = gpr_w_en && (gpr_w_addr != '0);

  // set_en implies busy[rd] was clear, so every set is a real 0->1
  assign cnt_inc = set_en;
  // A commit to a clear bit changes nothing in busy
  assign cnt_dec = commit && busy_q[gpr_w_addr];
  assign err_set = commit && !busy_q[gpr_w_addr];

  // Round-robin: on contention, grant whoever did not win last
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    unique case (1'b1)
      (wb0_valid && !wb1_valid): grant0 = 1'b1;
      (wb1_valid && !wb0_valid): grant1 = 1'b1;
      (wb0_valid && wb1_valid): begin
        grant0 = last_grant_q;
        grant1 = !last_grant_q;
      end
      default: ;
    endcase
  end

  assign wb0_ready = grant0;
  assign wb1_ready = grant1;

  // Set is applied after clear so a same-register collision stays busy
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_en) set_vec[issue_rd] = 1'b1;
    if (commit) clr_vec[gpr_w_addr] = 1'b1;
    busy_d    = (busy_q & ~clr_vec) | set_vec;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else if (grant0) begin
      last_grant_q <= 1'b0;
    end else if (grant1) begin
      last_grant_q <= 1'b1;
    end
  end

  // Registered write stage: one write per cycle, never back-pressures
  always_ff @(posedge clk) begin
    if (rst) begin
      gpr_w_en   <= 1'b0;
      gpr_w      <= '0;
      gpr_w_addr <= '0;
    end else begin
      gpr_w_en <= grant0 || grant1;
      if (grant0) begin
        gpr_w      <= wb0_data;
        gpr_w_addr <= wb0_addr;
      end else if (grant1) begin
        gpr_w      <= wb1_data;
        gpr_w_addr <= wb1_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_cnt <= '0;
    end else begin
      unique case ({cnt_inc, cnt_dec})
        2'b10:   pending_cnt <= pending_cnt + CNT_ONE;
        2'b01:   pending_cnt <= pending_cnt - CNT_ONE;
        default: pending_cnt <= pending_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_err <= 1'b0;
    end else if (err_set) begin
      wb_err <= 1'b1;
    end
  end

endmodule

// File: doc/ysyx_23060075_gpr_ctrl.md
Name: ysyx_23060075_gpr_ctrl

Overview:
- Write-back arbiter and scoreboard in front of the GPR register file.
- Shares the file's single write port between two write-back requesters (wb0 = EXU, wb1 = LSU) using round-robin arbitration and a registered write stage.
- Tracks pending destination registers and stalls issue on RAW/WAW hazards until the pending write commits.

Parameters:
- ADDR_WIDTH, 5, GPR address width; number of registers = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, GPR data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- issue_valid  in  1  instruction requests issue.
- issue_ready  out  1  issue allowed (combinational).
- issue_rs1  in  ADDR_WIDTH  source register 1.
- issue_rs2  in  ADDR_WIDTH  source register 2.
- issue_rd  in  ADDR_WIDTH  destination register.
- issue_rd_wen  in  1  instruction writes rd.
- wb0_valid  in  1  EXU write-back request.
- wb0_ready  out  1  EXU request granted this cycle.
- wb0_addr  in  ADDR_WIDTH  EXU destination.
- wb0_data  in  DATA_WIDTH  EXU data.
- wb1_valid  in  1  LSU write-back request.
- wb1_ready  out  1  LSU request granted this cycle.
- wb1_addr  in  ADDR_WIDTH  LSU destination.
- wb1_data  in  DATA_WIDTH  LSU data.
- gpr_w  out  DATA_WIDTH  register-file write data (registered).
- gpr_w_addr  out  ADDR_WIDTH  register-file write address (registered).
- gpr_w_en  out  1  register-file write enable (registered).
- pending_cnt  out  ADDR_WIDTH+1  number of set busy bits.
- wb_err  out  1  sticky flag: write-back to a non-busy, non-zero register.

Behaviour:
- Reset values:
  - busy[] all 0.
  - gpr_w_en = 0, gpr_w = 0, gpr_w_addr = 0.
  - pending_cnt = 0, wb_err = 0.
  - last_grant = 1, so wb0 wins the first contest.
- Reset takes effect at the next edge even mid-operation: it drops any in-flight write-stage entry and all busy bits.
- busy[0] is hard-wired 0 and is never set.
- Hazard check (combinational, uses registered busy only):
  - issue_ready = !busy[rs1] && !busy[rs2] && !(issue_rd_wen && busy[rd]).
  - issue_ready is independent of issue_valid.
- Issue fire = issue_valid && issue_ready. On fire with issue_rd_wen=1 and rd!=0, busy[rd] is set at the edge.
- Arbitration (combinational):
  - Only wb0_valid: wb0_ready=1.
  - Only wb1_valid: wb1_ready=1.
  - Both valid: grant the requester that is not last_grant.
  - Neither valid: both ready=0.
  - At most one ready is high in any cycle. ready never depends on ready.
  - last_grant updates only on a grant.
- Write stage, edge after a grant:
  - gpr_w_en=1; gpr_w and gpr_w_addr take the granted data and address.
  - No grant that cycle: gpr_w_en=0, while gpr_w and gpr_w_addr hold their values.
  - Latency is exactly 1 cycle from grant to gpr_w_en.
  - The stage never back-pressures; throughput is one write per cycle.
- Commit:
  - In a cycle with gpr_w_en=1 and gpr_w_addr!=0, busy[gpr_w_addr] clears at that edge, concurrent with the register-file write.
  - A dependent instruction therefore sees issue_ready=1 in the cycle after commit and reads the new value.
- Address 0 write-back: granted and driven to the register file (which masks it); no busy change; no wb_err.
- Write-back to a non-zero register whose busy bit is clear: still written; wb_err sets at commit and stays 1 until rst.
- Simultaneous set and clear of the same register (unreachable while the WAW stall holds): set wins, busy stays 1.
- pending_cnt:
  - Registered; +1 on a set, -1 on a clear, unchanged on both or neither.
  - Must always equal the popcount of busy[].

Test Plan:
- Reset then idle -> issue_ready=1 for rs1=3, rs2=4; gpr_w_en=0; pending_cnt=0; wb_err=0.
- Issue rd=5 wen=1; next cycle issue rs1=5 -> issue_ready=0. wb0 writes addr=5 data=0xDEADBEEF -> gpr_w_en=1 with addr 5 one cycle after grant; issue_ready=1 the following cycle; pending_cnt 1->0.
- busy[7]=busy[9]=1; wb0 (addr 7) and wb1 (addr 9) valid together for 2 cycles -> cycle 1 wb0_ready=1; cycle 2 wb1_ready=1; gpr_w_addr sequence 7 then 9; never both ready in one cycle.
- Issue rd=0 wen=1 -> pending_cnt stays 0; wb1 addr=0 -> gpr_w_en=1, wb_err=0.
- wb0 addr=12 with busy[12]=0 -> write occurs; wb_err=1 and stays 1 across later writes until rst.
- busy[3]=1 with a grant in flight; assert rst for one cycle -> next cycle gpr_w_en=0, pending_cnt=0, issue_ready=1 for rs1=3.
